// File: rtl/dfdd_pkg.sv
// Shared definitions for the DFDD front end: FP word width helper, coordinate width, window type.
// Pure declarations; no logic, no latency.
// No flow control here; users carry their own valid strobes.
package dfdd_pkg;

  localparam int COORD_WIDTH = 16;

  // Raw FP word width: sign + exponent + fraction
  function automatic int fp_width(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction

  localparam int FP_WIDTH_DEFAULT = fp_width(5, 10);

  // 2x2 window: [row][col], row 0 = previous image row, col 0 = left column
  typedef logic [1:0][1:0][FP_WIDTH_DEFAULT-1:0] window_t;

endpackage

// File: rtl/dfdd_line_buffer.sv
// One-row pixel store indexed by column; read is combinational, write lands on the clock edge.
// Latency: 0 cycles read (old contents visible in the write cycle), write takes effect next cycle.
// No backpressure; a write happens every cycle wr_en is high.
module dfdd_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_dat,
  output logic [WIDTH-1:0]  rd_dat
);

  // Contents are deliberately not reset: a row is always rewritten before it is read back
  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_dat = mem[addr];

  // Store the incoming pixel at its column; the read above still sees the previous row
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_dat;
    end
  end

endmodule

// File: rtl/dfdd_window_gen_2x2.sv
// Streaming 2x2 window generator feeding the DFDD level-0 downsampler from a raster FP16 stream.
// Latency: 1 cycle from the completing pixel to the registered window.
// No backpressure: every valid_i pixel is consumed; idle cycles change no state.
module dfdd_window_gen_2x2
  import dfdd_pkg::*;
#(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  localparam int FP_WIDTH_REG = fp_width(EXP_WIDTH, FRAC_WIDTH)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [FP_WIDTH_REG-1:0]             pixel_i,
  input  logic                                valid_i,
  input  logic                                sof_i,
  output logic [1:0][1:0][FP_WIDTH_REG-1:0]   window_o,
  output logic [COORD_WIDTH-1:0]              col_o,
  output logic [COORD_WIDTH-1:0]              row_o,
  output logic                                valid_o,
  output logic                                eof_o
);

  localparam int ADDR_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [COORD_WIDTH-1:0] LAST_COL = COORD_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] LAST_ROW = COORD_WIDTH'(IMAGE_HEIGHT - 1);

  logic [COORD_WIDTH-1:0]  col_q, row_q;
  logic [COORD_WIDTH-1:0]  cur_col, cur_row;
  logic                    col_last, row_last, emit;
  logic [FP_WIDTH_REG-1:0] top_rd;
  // top_q/cur_q hold the column-1 pixels of the previous and current rows; they shift into
  // the left column of the window on the same edge the window is registered, so no separate
  // left registers are kept.
  logic [FP_WIDTH_REG-1:0] top_q, cur_q;

  // Coordinate of the pixel on the input this cycle; sof forces it to the frame origin
  always_comb begin
    cur_col  = sof_i ? '0 : col_q;
    cur_row  = sof_i ? '0 : row_q;
    col_last = (cur_col == LAST_COL);
    row_last = (cur_row == LAST_ROW);
    emit     = valid_i && (cur_col != '0) && (cur_row != '0);
  end

  dfdd_line_buffer #(
    .DEPTH (IMAGE_WIDTH),
    .WIDTH (FP_WIDTH_REG)
  ) u_line_buffer (
    .clk    (clk_i),
    .addr   (cur_col[ADDR_W-1:0]),
    .wr_en  (valid_i),
    .wr_dat (pixel_i),
    .rd_dat (top_rd)
  );

  // Raster counters: advance per accepted pixel, wrap column at row end and row at frame end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (valid_i) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
    end
  end

  // Column-1 shift registers for the previous (line buffer) and current rows
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      top_q <= '0;
      cur_q <= '0;
    end else if (valid_i) begin
      top_q <= top_rd;
      cur_q <= pixel_i;
    end
  end

  // Output registers: window data holds between emissions, strobes last one cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      window_o <= '0;
      col_o    <= '0;
      row_o    <= '0;
      valid_o  <= 1'b0;
      eof_o    <= 1'b0;
    end else begin
      valid_o <= emit;
      eof_o   <= emit && col_last && row_last;
      if (emit) begin
        window_o[0][0] <= top_q;
        window_o[0][1] <= top_rd;
        window_o[1][0] <= cur_q;
        window_o[1][1] <= pixel_i;
        col_o          <= cur_col;
        row_o          <= cur_row;
      end
    end
  end

endmodule

// File: tb/tb_dfdd_window_gen_2x2.sv
// Scoreboard bench for dfdd_window_gen_2x2 on a 4x3 image, pixel value = raster index.
module tb_dfdd_window_gen_2x2;

  localparam int W = 4;
  localparam int H = 3;
  localparam int PW = 16;

  logic                     clk = 1'b0;
  logic                     rst_i = 1'b0;
  logic [PW-1:0]            pixel_i = '0;
  logic                     valid_i = 1'b0;
  logic                     sof_i = 1'b0;
  logic [1:0][1:0][PW-1:0]  window_o;
  logic [15:0]              col_o, row_o;
  logic                     valid_o, eof_o;

  dfdd_window_gen_2x2 #(
    .EXP_WIDTH    (5),
    .FRAC_WIDTH   (10),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .pixel_i  (pixel_i),
    .valid_i  (valid_i),
    .sof_i    (sof_i),
    .window_o (window_o),
    .col_o    (col_o),
    .row_o    (row_o),
    .valid_o  (valid_o),
    .eof_o    (eof_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w00, w01, w10, w11;
    int col, row;
    bit eof;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_vld = 0;
  int n_eof = 0;

  // Reference image of the frame in progress plus its raster position
  int img [H][W];
  int mc = 0;
  int mr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Pop and compare each emitted window; strobes must never appear unannounced
  always @(negedge clk) begin
    if (valid_o) begin
      n_vld++;
      if (eof_o) n_eof++;
      if (sb.size() == 0) begin
        chk("unexpected_window", 64'(1), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("win00", 64'(window_o[0][0]), 64'(mon_e.w00));
        chk("win01", 64'(window_o[0][1]), 64'(mon_e.w01));
        chk("win10", 64'(window_o[1][0]), 64'(mon_e.w10));
        chk("win11", 64'(window_o[1][1]), 64'(mon_e.w11));
        chk("col", 64'(col_o), 64'(mon_e.col));
        chk("row", 64'(row_o), 64'(mon_e.row));
        chk("eof", 64'(eof_o), 64'(mon_e.eof));
        chk("latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end else begin
      chk("eof_without_valid", 64'(eof_o), 64'(0));
    end
  end

  task automatic send(input int pix, input bit sof);
    exp_t e;
    @(negedge clk);
    valid_i = 1'b1;
    sof_i   = sof;
    pixel_i = PW'(pix);
    if (sof) begin
      mc = 0;
      mr = 0;
    end
    img[mr][mc] = pix;
    if (mc >= 1 && mr >= 1) begin
      e.w00 = img[mr-1][mc-1];
      e.w01 = img[mr-1][mc];
      e.w10 = img[mr][mc-1];
      e.w11 = pix;
      e.col = mc;
      e.row = mr;
      e.eof = (mc == W-1) && (mr == H-1);
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    if (mc == W-1) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0;
      sof_i   = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int budget = 10;
    idle(1);
    while (sb.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    idle(1);
    chk(tag, 64'(sb.size()), 64'(0));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_win"}, 64'(window_o), 64'(0));
    chk({tag, "_col"}, 64'(col_o), 64'(0));
    chk({tag, "_row"}, 64'(row_o), 64'(0));
    chk({tag, "_vld"}, 64'(valid_o), 64'(0));
    chk({tag, "_eof"}, 64'(eof_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0;

    // Reset state, then 20 idle cycles with outputs at zero
    repeat (3) @(negedge clk);
    chk_zero_outputs("in_reset");
    rst_i = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk_zero_outputs("idle");
    end

    // Continuous frame with sof on the first pixel
    v0 = n_vld; e0 = n_eof;
    for (int k = 0; k < W*H; k++) send(k, k == 0);
    drain("t1_drain");
    chk("t1_pulses", 64'(n_vld - v0), 64'(6));
    chk("t1_eofs", 64'(n_eof - e0), 64'(1));
    chk("t1_last_win00", 64'(window_o[0][0]), 64'(6));
    chk("t1_last_win11", 64'(window_o[1][1]), 64'(11));

    // Same frame, valid low every other cycle
    v0 = n_vld; e0 = n_eof;
    for (int k = 0; k < W*H; k++) begin
      send(k, k == 0);
      idle(1);
    end
    drain("t2_drain");
    chk("t2_pulses", 64'(n_vld - v0), 64'(6));
    chk("t2_eofs", 64'(n_eof - e0), 64'(1));

    // Two frames back to back, sof only on the first
    v0 = n_vld; e0 = n_eof;
    for (int k = 0; k < 2*W*H; k++) send(k, k == 0);
    drain("t3_drain");
    chk("t3_pulses", 64'(n_vld - v0), 64'(12));
    chk("t3_eofs", 64'(n_eof - e0), 64'(2));
    chk("t3_last_win00", 64'(window_o[0][0]), 64'(18));

    // sof reasserted at k=6 aborts the first frame
    v0 = n_vld; e0 = n_eof;
    for (int k = 0; k < 6; k++) send(k, k == 0);
    for (int k = 6; k < 6 + W*H; k++) send(k, k == 6);
    drain("t4_drain");
    chk("t4_pulses", 64'(n_vld - v0), 64'(7));
    chk("t4_eofs", 64'(n_eof - e0), 64'(1));

    // Reset for one cycle after k=7; next pixel restarts at the origin without sof
    v0 = n_vld; e0 = n_eof;
    for (int k = 0; k < 8; k++) send(k, k == 0);
    idle(1);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    mc = 0;
    mr = 0;
    @(negedge clk);
    rst_i = 1'b1;
    for (int k = 100; k < 100 + W*H; k++) send(k, 1'b0);
    drain("t5_drain");
    chk("t5_pulses", 64'(n_vld - v0), 64'(9));
    chk("t5_eofs", 64'(n_eof - e0), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dfdd_window_gen_2x2.md
# dfdd_window_gen_2x2

Streaming 2×2 window generator that sits directly upstream of the DFDD level-0 downsampler. It accepts a raster-ordered FP16 pixel stream, one pixel per valid cycle, and stores the previous image row in a line buffer. Each time a pixel completes a full 2×2 neighbourhood, it emits that window with its column/row coordinates and a valid strobe. The output port shape matches the downsampler's window/col/row/valid inputs one-to-one.

## Interface
Parameters:
- EXP_WIDTH, 5, FP exponent bits
- FRAC_WIDTH, 10, FP fraction bits
- IMAGE_WIDTH, 640, pixels per row (≥2)
- IMAGE_HEIGHT, 480, rows per frame (≥2)
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, local, pixel word width

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset, asynchronous assert, active-low, synchronous deassert at the instantiating level
- pixel_i  in  FP_WIDTH_REG  input pixel, raw FP bits, never interpreted
- valid_i  in  1  pixel_i is accepted this cycle; there is no backpressure
- sof_i  in  1  start of frame; meaningful only when valid_i=1
- window_o  out  FP_WIDTH_REG [2][2]  [0][*] is the previous row, [1][*] is the current row; [*][0] is col-1, [*][1] is col
- col_o  out  16  column of the window's bottom-right pixel
- row_o  out  16  row of the window's bottom-right pixel
- valid_o  out  1  window_o, col_o and row_o are valid
- eof_o  out  1  pulses with the last window of a frame

## Operation
- Internal counters col_q/row_q track the coordinate of the next accepted pixel. Reset value is 0/0.
- When valid_i=1 and sof_i=1, the pixel is taken as (0,0) regardless of the counters. Counters then continue from (1,0), which resynchronises the frame. sof_i is ignored when valid_i=0.
- For an accepted pixel p at (c,r):
  - Read top = linebuf[c], then write linebuf[c] ← p (read-before-write, same cycle).
  - Shift registers: left_top ← top_q, top_q ← top, left_cur ← cur_q, cur_q ← p.
- Counter advance:
  - If c = IMAGE_WIDTH-1, set col_q=0 and increment row_q.
  - If additionally r = IMAGE_HEIGHT-1, set row_q=0 (frame wraps).
  - Otherwise increment col_q.
- Window emission:
  - A window is emitted iff c ≥ 1 and r ≥ 1.
  - Values: window_o = {{left_top, top}, {left_cur, p}}, col_o=c, row_o=r.
  - eof_o=1 iff c=IMAGE_WIDTH-1 and r=IMAGE_HEIGHT-1.
- Row 0 and column 0 never emit. Stale line-buffer data and stale left registers from the previous row are therefore never visible.
- Line-buffer contents are not reset. The registers are reset.
- Cycles with valid_i=0 change no state.

## Timing
- Latency is 1 cycle: outputs register on the edge that accepts the completing pixel.
- valid_o and eof_o are single-cycle strobes per accepted pixel.
- Back-to-back pixels give one window per cycle in steady state, (IMAGE_WIDTH-1)·(IMAGE_HEIGHT-1) windows per frame.
- When valid_o=0, window_o, col_o and row_o hold their last values.
- Reset values:
  - window_o all 0, col_o=0, row_o=0, valid_o=0, eof_o=0.
  - col_q=0, row_q=0, shift registers 0.
- Reset asserted mid-frame clears all of the above immediately. The first accepted pixel after release is (0,0), with or without sof_i.
- sof_i mid-frame discards the partial frame. No eof_o is produced for the discarded frame.

## Structure
- Shared package dfdd_pkg holds:
  - fp_width(EXP_WIDTH, FRAC_WIDTH) function
  - COORD_WIDTH=16
  - window type typedef parameterised by width
- Sub-module dfdd_line_buffer:
  - depth IMAGE_WIDTH, width FP_WIDTH_REG
  - one address, combinational read-before-write, write-enable = valid_i
  - register array, inferable as distributed RAM
- Top level contains the counters, the shift registers, and the output registers.

## Test plan
Use IMAGE_WIDTH=4, IMAGE_HEIGHT=3. Pixel k (raster index) is driven as raw value k.
- Continuous frame, sof_i on k=0:
  - exactly 6 valid_o pulses.
  - first pulse, one cycle after k=5: window [[0,1],[4,5]], col_o=1, row_o=1.
  - last pulse, after k=11: window [[6,7],[10,11]], col 3, row 2, eof_o=1.
- Same frame with valid_i low on every other cycle → identical 6 windows; each one arrives one cycle after its completing pixel.
- Two frames back-to-back with no sof_i on the second → second frame windows identical with values +12. Row 0 of the second frame emits nothing.
- sof_i reasserted at k=6 of the first frame → no eof_o for the aborted frame; the next 12 pixels produce the standard 6-window sequence from (1,1).
- rst_i low for 1 cycle after k=7 → all outputs read 0 during reset; the next pixel is treated as (0,0); the first window comes after the 6th post-reset pixel at (1,1).
- Reset state → with no valid_i, all outputs stay 0 for 20 cycles.
